bus_initiator: RTL and testbench
================================

# bus_initiator

Bus initiator for the shared 8-bit peripheral bus (BUS_ADDR / BUS_DATA / BUS_WE) used by the memory-mapped register-bank peripherals such as the seven-segment driver at 0xD0–0xD2. It accepts single-word read/write commands over a valid/ready port and sequences them onto the bus. It manages the tri-state data line, the registered-responder read latency and read-to-write turnaround, and returns one response per transfer. It lets a non-processor master, such as a debug UART or test sequencer, reach every bus peripheral.

## Interface
- IDLE_ADDR, 8'hFF: address driven whenever no transfer is active; no responder may decode it.
- READ_WAIT, 1: extra address-hold cycles before read data is sampled; range 1..7.
- CLK2  in  1  bus clock, rising edge; the same clock the bus responders use.
- RESET  in  1  synchronous, active-high; clock CLK2.
- REQ_VALID  in  1  command valid.
- REQ_READY  out  1  command accepted when REQ_VALID & REQ_READY at a rising edge.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  8  start address.
- REQ_WDATA  in  8  write data.
- REQ_LEN  in  4  beat count − 1; present only with BUS_INIT_BURST_EN.
- RSP_VALID  out  1  one-cycle pulse, one per completed beat; no backpressure.
- RSP_WE  out  1  type of the completed beat.
- RSP_RDATA  out  8  read data; 8'h00 for write beats.
- BUSY  out  1  high from acceptance until the state returns to IDLE.
- BUS_ADDR  out  8  bus address.
- BUS_WE  out  1  bus write strobe.
- BUS_DATA  inout  8  driven only during WRITE, otherwise 8'hZZ.

## Operation
- States and transitions:
  - IDLE → WRITE or READ on acceptance.
  - WRITE → IDLE.
  - READ → TURN.
  - TURN → IDLE.
  - Burst transitions are covered under Configuration.
- IDLE:
  - BUS_ADDR=IDLE_ADDR, BUS_WE=0, BUS_DATA hi-Z.
  - REQ_READY = (state==IDLE) & ~RESET.
  - The command is latched on acceptance. REQ_* inputs are ignored at all other times.
- WRITE: BUS_ADDR=addr, BUS_WE=1, BUS_DATA=wdata for exactly one cycle per beat.
- READ:
  - BUS_ADDR=addr, BUS_WE=0, BUS_DATA hi-Z, held for READ_WAIT+1 cycles per beat.
  - BUS_DATA is sampled at the rising edge that ends the last cycle.
- TURN:
  - One cycle with BUS_ADDR=IDLE_ADDR and BUS_DATA hi-Z.
  - This lets the registered responder release the bus before any later write.
  - TURN is mandatory after every read.
- Reset values:
  - BUS_ADDR=IDLE_ADDR, BUS_WE=0, BUS_DATA hi-Z.
  - RSP_VALID=0, RSP_WE=0, RSP_RDATA=0, BUSY=0.
  - REQ_READY=0 while RESET is high, and 1 in the first cycle after it.
- Reset mid-transfer:
  - Abort the transfer and go to IDLE at the reset edge.
  - The bus is released in the next cycle.
  - No response is emitted for the aborted beat.
- Address arithmetic is modulo 256: 8'hFF + 1 = 8'h00.
- The block does not check whether a responder exists. A read of an empty address returns whatever BUS_DATA resolves to.

## Timing
- Edge E0 is the acceptance edge. All outputs are registered.
- Write:
  - Bus phase in cycle 1; the responder captures at E1.
  - RSP_VALID in cycle 2, with state already IDLE (REQ_READY=1).
  - Maximum throughput is one single write per 2 cycles.
- Read, with the default READ_WAIT=1:
  - Address in cycles 1–2; sample at E2.
  - TURN plus RSP_VALID with data in cycle 3.
  - IDLE in cycle 4.
- Read, general case: RSP_VALID in cycle READ_WAIT+2.
- An accept in the cycle RSP_VALID is high is legal for writes. After a read, acceptance is possible from cycle READ_WAIT+3.

## Configuration
- Macro: BUS_INIT_BURST_EN.
- Defined:
  - The REQ_LEN port exists, and a command performs REQ_LEN+1 beats at addr, addr+1, … (wrapping).
  - Write bursts drive REQ_WDATA on every beat ("fill"), one beat per cycle.
  - Read bursts run back-to-back with READ_WAIT+1 cycles per beat and no TURN between beats; a single TURN follows the last beat.
  - RSP_VALID pulses once per beat, one cycle after that beat's final cycle.
  - BUSY stays high across the whole burst.
- Undefined: the REQ_LEN port is absent and behaviour equals LEN=0.

## Structure
- Package bus_init_pkg holds:
  - the state typedef (IDLE, WRITE, READ, TURN);
  - BUS_AW=8 and BUS_DW=8;
  - the default IDLE_ADDR constant.
- A single module. No sub-module is natural: the datapath is one address counter, one beat counter, one wait counter and a data register.

## Test plan
- Write 0xD0←0xA5 against a responder model of the seven-segment register bank → BUS_WE=1 with BUS_DATA=0xA5 for exactly 1 cycle; RSP_VALID in cycle 2 with RSP_WE=1; model reg0=0xA5.
- Read 0xD1 (preloaded 0x3C), READ_WAIT=1 → address held 2 cycles; RSP_RDATA=0x3C in cycle 3; BUS_DATA never driven by the DUT; REQ_READY back in cycle 4.
- Read 0xD0 then an immediate write 0xD2←0x0F → a TURN cycle with BUS_ADDR=0xFF separates them; no cycle with two drivers (no X on BUS_DATA).
- Burst (macro on) read LEN=2 from 0xD0 → three RSP_VALID pulses carrying reg0, reg1, reg2; BUSY high throughout; a single TURN at the end.
- Burst write LEN=1 at 0xFF with data 0x11 → beats at 0xFF then 0x00, both with data 0x11 (wrap).
- RESET asserted during the second READ cycle → next cycle BUS_ADDR=IDLE_ADDR, BUS_WE=0, no RSP_VALID, BUSY=0; REQ_READY=1 after RESET drops.

Source files
------------

// File: rtl/bus_init_pkg.sv
// rtl/bus_init_pkg.sv - shared types and constants for the peripheral bus initiator
package bus_init_pkg;

  localparam int BUS_AW = 8;
  localparam int BUS_DW = 8;

  // No responder decodes this address, so it is safe to park on it.
  localparam logic [BUS_AW-1:0] DEFAULT_IDLE_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

endpackage

// File: rtl/bus_initiator_if.sv
// rtl/bus_initiator_if.sv - command/response and bus-control signals of bus_initiator
// BUS_INIT_BURST_EN adds the REQ_LEN beat-count field.
interface bus_initiator_if;
  import bus_init_pkg::*;

  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WE;
  logic [BUS_AW-1:0] REQ_ADDR;
  logic [BUS_DW-1:0] REQ_WDATA;
`ifdef BUS_INIT_BURST_EN
  logic [3:0]        REQ_LEN;
`endif
  logic              RSP_VALID;
  logic              RSP_WE;
  logic [BUS_DW-1:0] RSP_RDATA;
  logic              BUSY;
  logic [BUS_AW-1:0] BUS_ADDR;
  logic              BUS_WE;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
`ifdef BUS_INIT_BURST_EN
    input  REQ_LEN,
`endif
    output REQ_READY, RSP_VALID, RSP_WE, RSP_RDATA, BUSY, BUS_ADDR, BUS_WE
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
`ifdef BUS_INIT_BURST_EN
    output REQ_LEN,
`endif
    input  REQ_READY, RSP_VALID, RSP_WE, RSP_RDATA, BUSY, BUS_ADDR, BUS_WE
  );

endinterface

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - sequences single-word (or BUS_INIT_BURST_EN burst) commands onto the 8-bit peripheral bus
module bus_initiator
  import bus_init_pkg::*;
#(
  parameter logic [BUS_AW-1:0] IDLE_ADDR = DEFAULT_IDLE_ADDR,
  parameter int unsigned       READ_WAIT = 1
) (
  input  logic              CLK2,
  input  logic              RESET,
  bus_initiator_if.master   bif,
  inout  wire  [BUS_DW-1:0] BUS_DATA
);

  localparam logic [2:0] WAIT_LOAD = 3'(READ_WAIT);

  state_t            r_state,     w_state_n;
  logic [BUS_AW-1:0] r_addr,      w_addr_n;
  logic [BUS_DW-1:0] r_wdata,     w_wdata_n;
  logic [3:0]        r_beats,     w_beats_n;
  logic [2:0]        r_wait,      w_wait_n;
  logic [BUS_AW-1:0] r_bus_addr,  w_bus_addr_n;
  logic              r_bus_we,    w_bus_we_n;
  logic              r_rsp_valid, w_rsp_valid_n;
  logic              r_rsp_we,    w_rsp_we_n;
  logic [BUS_DW-1:0] r_rsp_rdata, w_rsp_rdata_n;
  logic              r_busy;
  logic              w_req_ready;
  logic              w_accept;
  logic [3:0]        w_req_len;
  logic [BUS_AW-1:0] w_addr_inc;

`ifdef BUS_INIT_BURST_EN
  assign w_req_len = bif.REQ_LEN;
`else
  assign w_req_len = 4'd0;
`endif

  assign w_req_ready = (r_state == IDLE) & ~RESET;
  assign w_accept    = bif.REQ_VALID & w_req_ready;
  assign w_addr_inc  = r_addr + 1'b1;

  always_comb begin
    w_state_n     = r_state;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;
    w_beats_n     = r_beats;
    w_wait_n      = r_wait;
    w_bus_addr_n  = IDLE_ADDR;
    w_bus_we_n    = 1'b0;
    w_rsp_valid_n = 1'b0;
    w_rsp_we_n    = r_rsp_we;
    w_rsp_rdata_n = r_rsp_rdata;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_addr_n     = bif.REQ_ADDR;
          w_wdata_n    = bif.REQ_WDATA;
          w_beats_n    = w_req_len;
          w_wait_n     = WAIT_LOAD;
          w_bus_addr_n = bif.REQ_ADDR;
          if (bif.REQ_WE) begin
            w_state_n  = WRITE;
            w_bus_we_n = 1'b1;
          end else begin
            w_state_n  = READ;
          end
        end
      end

      WRITE: begin
        w_rsp_valid_n = 1'b1;
        w_rsp_we_n    = 1'b1;
        w_rsp_rdata_n = '0;
        if (r_beats == 4'd0) begin
          w_state_n = IDLE;
        end else begin
          w_beats_n    = r_beats - 1'b1;
          w_addr_n     = w_addr_inc;
          w_bus_addr_n = w_addr_inc;
          w_bus_we_n   = 1'b1;
        end
      end

      READ: begin
        w_bus_addr_n = r_addr;
        // Last cycle of the beat: the registered responder is driving by now.
        if (r_wait == 3'd0) begin
          w_rsp_valid_n = 1'b1;
          w_rsp_we_n    = 1'b0;
          w_rsp_rdata_n = BUS_DATA;
          if (r_beats == 4'd0) begin
            w_state_n    = TURN;
            w_bus_addr_n = IDLE_ADDR;
          end else begin
            w_beats_n    = r_beats - 1'b1;
            w_addr_n     = w_addr_inc;
            w_bus_addr_n = w_addr_inc;
            w_wait_n     = WAIT_LOAD;
          end
        end else begin
          w_wait_n = r_wait - 1'b1;
        end
      end

      TURN: begin
        w_state_n = IDLE;
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK2) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_beats     <= '0;
      r_wait      <= '0;
      r_bus_addr  <= IDLE_ADDR;
      r_bus_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_beats     <= w_beats_n;
      r_wait      <= w_wait_n;
      r_bus_addr  <= w_bus_addr_n;
      r_bus_we    <= w_bus_we_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_we    <= w_rsp_we_n;
      r_rsp_rdata <= w_rsp_rdata_n;
      r_busy      <= (w_state_n != IDLE);
    end
  end

  // The data line is ours only while the write strobe is up.
  assign BUS_DATA = r_bus_we ? r_wdata : {BUS_DW{1'bz}};

  assign bif.REQ_READY = w_req_ready;
  assign bif.RSP_VALID = r_rsp_valid;
  assign bif.RSP_WE    = r_rsp_we;
  assign bif.RSP_RDATA = r_rsp_rdata;
  assign bif.BUSY      = r_busy;
  assign bif.BUS_ADDR  = r_bus_addr;
  assign bif.BUS_WE    = r_bus_we;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - scoreboard bench for bus_initiator with a registered 0xD0-0xD2 responder
module tb_bus_initiator;

  localparam int RW = 1;

  typedef struct {
    int         cyc;
    logic       we;
    logic [7:0] rd;
  } rsp_t;

  logic CLK2 = 1'b0;
  logic RESET = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  bus_initiator_if bif ();
  wire [7:0] bus_data;

  bus_initiator dut (
    .CLK2     (CLK2),
    .RESET    (RESET),
    .bif      (bif),
    .BUS_DATA (bus_data)
  );

  always #5 CLK2 = ~CLK2;
  always @(posedge CLK2) cyc <= cyc + 1;

  // Seven-segment style register bank: registered read data, so it keeps
  // driving one cycle after the address leaves its range.
  logic [7:0] bank [3] = '{8'h10, 8'h20, 8'h30};
  logic       resp_oe = 1'b0;
  logic [7:0] resp_q = 8'h00;

  function automatic logic mapped(input logic [7:0] a);
    return (a >= 8'hD0) && (a <= 8'hD2);
  endfunction

  always @(posedge CLK2) begin
    if (bif.BUS_WE && mapped(bif.BUS_ADDR)) bank[2'(bif.BUS_ADDR - 8'hD0)] <= bus_data;
    resp_oe <= !bif.BUS_WE && mapped(bif.BUS_ADDR);
    resp_q  <= mapped(bif.BUS_ADDR) ? bank[2'(bif.BUS_ADDR - 8'hD0)] : 8'h00;
  end
  assign bus_data = resp_oe ? resp_q : 8'hzz;

  // Reference: expected bus timeline per cycle, expected responses, model memory.
  logic [7:0] model_mem [3] = '{8'h10, 8'h20, 8'h30};
  logic [7:0] exp_addr [int];
  logic [7:0] exp_wd [int];
  rsp_t       rsp_q [$];
  int         busy_lo = 0;
  int         busy_hi = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge CLK2) begin
    automatic int         c = cyc;
    automatic logic [7:0] ea;
    automatic logic       ewe;
    automatic logic       eb;
    ea  = exp_addr.exists(c) ? exp_addr[c] : 8'hFF;
    ewe = exp_wd.exists(c);
    chk("bus_addr", bif.BUS_ADDR, ea);
    chk("bus_we", bif.BUS_WE, ewe);
    if (ewe && bif.BUS_WE) chk("bus_wdata", bus_data, exp_wd[c]);
    if (bif.BUS_WE) chk("bus_contention", resp_oe, 1'b0);
    if (exp_addr.exists(c)) exp_addr.delete(c);
    if (exp_wd.exists(c)) exp_wd.delete(c);
    eb = (c >= busy_lo) && (c <= busy_hi);
    chk("busy", bif.BUSY, eb);
    chk("req_ready", bif.REQ_READY, !eb && !RESET);
    while (rsp_q.size() > 0 && rsp_q[0].cyc < c) begin
      chk("rsp_missing", 1'b0, 1'b1);
      void'(rsp_q.pop_front());
    end
    if (bif.RSP_VALID) begin
      if (rsp_q.size() == 0 || rsp_q[0].cyc != c) begin
        chk("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        chk("rsp_we", bif.RSP_WE, rsp_q[0].we);
        chk("rsp_rdata", bif.RSP_RDATA, rsp_q[0].rd);
        void'(rsp_q.pop_front());
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].cyc == c) begin
      chk("rsp_valid", 1'b0, 1'b1);
      void'(rsp_q.pop_front());
    end
  end

  // Call at posedge+2; returns at posedge+2 of the cycle after acceptance.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wd, input int len);
    int   a0;
    logic got;
    bif.REQ_VALID = 1'b1;
    bif.REQ_WE    = we;
    bif.REQ_ADDR  = addr;
    bif.REQ_WDATA = wd;
`ifdef BUS_INIT_BURST_EN
    bif.REQ_LEN   = 4'(len);
`endif
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge CLK2);
      if (bif.REQ_READY) got = 1'b1;
    end
    chk("accept", got, 1'b1);
    if (got) begin
      a0 = cyc + 1;
      for (int i = 0; i <= len; i++) begin
        logic [7:0] ad;
        rsp_t       e;
        ad = addr + 8'(i);
        if (we) begin
          exp_addr[a0 + i] = ad;
          exp_wd[a0 + i]   = wd;
          e.cyc = a0 + 1 + i; e.we = 1'b1; e.rd = 8'h00;
          if (mapped(ad)) model_mem[2'(ad - 8'hD0)] = wd;
        end else begin
          for (int k = 0; k <= RW; k++) exp_addr[a0 + i * (RW + 1) + k] = ad;
          e.cyc = a0 + (i + 1) * (RW + 1); e.we = 1'b0; e.rd = model_mem[2'(ad - 8'hD0)];
        end
        rsp_q.push_back(e);
      end
      busy_lo = a0;
      busy_hi = we ? a0 + len : a0 + (len + 1) * (RW + 1);
    end
    @(posedge CLK2); #2;
    bif.REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge CLK2);
      if (rsp_q.size() == 0 && !bif.BUSY) done = 1'b1;
    end
    chk("idle_timeout", done, 1'b1);
    @(posedge CLK2); #2;
  endtask

  // Reset aborts the transfer: drop every expectation after the current cycle.
  task automatic abort_expectations(input int c);
    int   ks [$];
    rsp_t keep [$];
    foreach (exp_addr[k]) if (k > c) ks.push_back(k);
    foreach (ks[j]) exp_addr.delete(ks[j]);
    ks = {};
    foreach (exp_wd[k]) if (k > c) ks.push_back(k);
    foreach (ks[j]) exp_wd.delete(ks[j]);
    foreach (rsp_q[j]) if (rsp_q[j].cyc <= c) keep.push_back(rsp_q[j]);
    rsp_q = keep;
    if (busy_hi > c) busy_hi = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.REQ_VALID = 1'b0;
    bif.REQ_WE    = 1'b0;
    bif.REQ_ADDR  = 8'h00;
    bif.REQ_WDATA = 8'h00;
`ifdef BUS_INIT_BURST_EN
    bif.REQ_LEN   = 4'd0;
`endif
    @(negedge CLK2);
    chk("reset_rsp_valid", bif.RSP_VALID, 1'b0);
    chk("reset_rsp_we", bif.RSP_WE, 1'b0);
    chk("reset_rsp_rdata", bif.RSP_RDATA, 8'h00);
    repeat (2) @(posedge CLK2);
    #2 RESET = 1'b0;

    issue(1'b1, 8'hD0, 8'hA5, 0);
    wait_idle();
    chk("bank0_after_write", bank[0], 8'hA5);

    issue(1'b1, 8'hD1, 8'h3C, 0);
    wait_idle();
    issue(1'b0, 8'hD1, 8'h00, 0);
    wait_idle();

    issue(1'b0, 8'hD0, 8'h00, 0);
    issue(1'b1, 8'hD2, 8'h0F, 0);
    wait_idle();
    chk("bank2_after_write", bank[2], 8'h0F);

`ifdef BUS_INIT_BURST_EN
    issue(1'b0, 8'hD0, 8'h00, 2);
    wait_idle();
    issue(1'b1, 8'hFF, 8'h11, 1);
    wait_idle();
`endif

    issue(1'b0, 8'hD1, 8'h00, 0);
    @(posedge CLK2); #2;
    RESET = 1'b1;
    abort_expectations(cyc);
    @(posedge CLK2); #2;
    RESET = 1'b0;
    wait_idle();

    for (int n = 0; n < 60; n++) begin
      logic       we;
      logic [7:0] ad;
      int         len;
      int         r;
      we  = 1'($urandom_range(0, 1));
      len = 0;
      if (we) begin
        r  = $urandom_range(0, 1);
        ad = r ? 8'($urandom_range(0, 255)) : 8'(8'hD0 + $urandom_range(0, 2));
`ifdef BUS_INIT_BURST_EN
        len = $urandom_range(0, 3);
`endif
        issue(1'b1, ad, 8'($urandom_range(0, 255)), len);
      end else begin
        r  = $urandom_range(0, 2);
        ad = 8'(8'hD0 + r);
`ifdef BUS_INIT_BURST_EN
        len = $urandom_range(0, 2 - r);
`endif
        issue(1'b0, ad, 8'h00, len);
      end
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge CLK2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
